// File: rtl/acc_drain.sv
// Drains accumulator rows through a 2-entry skid FIFO onto a valid/ready stream.
// Optional macro ACC_DRAIN_RELU_EN clamps negative int8 lanes to zero on capture.
module acc_drain #(
    parameter int ADDR_W     = 4,
    parameter int DOUT_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W:0]       row_cnt,
    output logic                  busy,
    output logic                  done,
    output logic                  acc_enb,
    output logic [ADDR_W-1:0]     acc_addrb,
    input  logic [DOUT_WIDTH-1:0] acc_doutb,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DOUT_WIDTH-1:0] m_data,
    output logic                  m_last
);

    localparam int LANES = DOUT_WIDTH / 8;
    localparam logic [ADDR_W:0] ONE = 1;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t                     state_q, state_d;
    logic [ADDR_W:0]            left_q, left_d;
    logic [ADDR_W-1:0]          addr_q, addr_d;
    logic [ADDR_W-1:0]          hold_q, hold_d;
    logic                       infl_q, infl_d;
    logic                       infl_last_q, infl_last_d;
    logic [1:0][DOUT_WIDTH-1:0] fdata_q, fdata_d;
    logic [1:0]                 flast_q, flast_d;
    logic                       wp_q, wp_d;
    logic                       rp_q, rp_d;
    logic [1:0]                 cnt_q, cnt_d;
    logic                       done_q, done_d;

    logic                       pop;
    logic                       room;
    logic                       issue;
    logic                       issue_last;
    logic [ADDR_W-1:0]          rd_addr;

    function automatic logic [DOUT_WIDTH-1:0] shape(
        input logic [DOUT_WIDTH-1:0] v
    );
        logic [DOUT_WIDTH-1:0] r;
        r = v;
`ifdef ACC_DRAIN_RELU_EN
        for (int i = 0; i < LANES; i++) begin
            if (v[8*i+7]) begin
                r[8*i +: 8] = '0;
            end
        end
`else
        r = v;
`endif
        return r;
    endfunction

    always_comb begin
        pop   = (cnt_q != 2'd0) && m_ready;
        cnt_d = cnt_q + {1'b0, infl_q} - {1'b0, pop};
        // Credit check: rows held plus reads outstanding after this edge.
        room  = (cnt_d < 2'd2);

        state_d    = state_q;
        left_d     = left_q;
        addr_d     = addr_q;
        done_d     = 1'b0;
        issue      = 1'b0;
        issue_last = 1'b0;
        rd_addr    = addr_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (row_cnt != '0) begin
                        issue      = 1'b1;
                        issue_last = (row_cnt == ONE);
                        rd_addr    = base_addr;
                        addr_d     = base_addr + 1'b1;
                        left_d     = row_cnt - ONE;
                        state_d    = RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (left_q != '0 && room) begin
                    issue      = 1'b1;
                    issue_last = (left_q == ONE);
                    addr_d     = addr_q + 1'b1;
                    left_d     = left_q - ONE;
                end
                if (left_d == '0) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (pop && flast_q[rp_q]) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        acc_enb     = issue && rst_n;
        acc_addrb   = acc_enb ? rd_addr : hold_q;
        hold_d      = acc_addrb;
        infl_d      = issue;
        infl_last_d = issue_last;

        fdata_d = fdata_q;
        flast_d = flast_q;
        wp_d    = wp_q;
        rp_d    = rp_q;
        if (infl_q) begin
            fdata_d[wp_q] = shape(acc_doutb);
            flast_d[wp_q] = infl_last_q;
            wp_d          = ~wp_q;
        end
        if (pop) begin
            rp_d = ~rp_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            left_q      <= '0;
            addr_q      <= '0;
            hold_q      <= '0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
            fdata_q     <= '0;
            flast_q     <= '0;
            wp_q        <= 1'b0;
            rp_q        <= 1'b0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            left_q      <= left_d;
            addr_q      <= addr_d;
            hold_q      <= hold_d;
            infl_q      <= infl_d;
            infl_last_q <= infl_last_d;
            fdata_q     <= fdata_d;
            flast_q     <= flast_d;
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign m_valid = (cnt_q != 2'd0);
    assign m_data  = fdata_q[rp_q];
    assign m_last  = m_valid && flast_q[rp_q];

endmodule

// File: tb/tb_acc_drain.sv
// Randomized bench for acc_drain against a queue-based reference of rows and beats.
// Honors ACC_DRAIN_RELU_EN the same way as the design build.
module tb_acc_drain;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [3:0]   base_addr;
    logic [4:0]   row_cnt;
    logic         busy;
    logic         done;
    logic         acc_enb;
    logic [3:0]   acc_addrb;
    logic [127:0] acc_doutb;
    logic         m_valid;
    logic         m_ready;
    logic [127:0] m_data;
    logic         m_last;

    acc_drain #(.ADDR_W(4), .DOUT_WIDTH(128)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .base_addr(base_addr), .row_cnt(row_cnt),
        .busy(busy), .done(done),
        .acc_enb(acc_enb), .acc_addrb(acc_addrb), .acc_doutb(acc_doutb),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [127:0] mem [16];
    always @(posedge clk) if (acc_enb) acc_doutb <= mem[acc_addrb];

    function automatic logic [127:0] ref_row(input logic [127:0] v);
        logic [127:0] r;
        logic signed [7:0] b;
        r = v;
`ifdef ACC_DRAIN_RELU_EN
        for (int i = 0; i < 16; i++) begin
            b = v[8*i +: 8];
            if (b < 0) r[8*i +: 8] = 8'h00;
        end
`endif
        return r;
    endfunction

    logic [127:0] exp_q[$];
    int           exp_addr_q[$];
    int           beats, first_cyc, last_beat_cyc, done_cyc, done_n;
    int           outstanding;
    logic         stall_prev, prev_last;
    logic [127:0] prev_data, last_data;
    int           ready_mode = 0;
    int           pi = 0;
    bit           pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1: m_ready = 1'($urandom % 2);
                2: begin m_ready = pat[pi % 4]; pi++; end
                default: m_ready = 1'b1;
            endcase
        end
    end

    always @(negedge clk) begin
        logic pop;
        logic [127:0] e;
        if (!rst_n) begin
            outstanding = 0;
            stall_prev  = 1'b0;
        end else begin
            pop = m_valid && m_ready;
            if (stall_prev) begin
                chk("stall_valid", m_valid, 1'b1);
                chk("stall_data", m_data, prev_data);
                chk("stall_last", m_last, prev_last);
            end
            if (acc_enb) begin
                if (exp_addr_q.size() == 0) chk("read_unexp", 1, 0);
                else chk("read_addr", acc_addrb, exp_addr_q.pop_front());
                chk("credit", (outstanding - int'(pop) + 1) <= 2, 1);
            end
            if (pop) begin
                if (exp_q.size() == 0) begin
                    chk("beat_unexp", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", m_data, e);
                    chk("beat_last", m_last, exp_q.size() == 0);
                    if (beats == 0) first_cyc = cyc;
                    beats++;
                    last_beat_cyc = cyc;
                    last_data = m_data;
                end
            end
            if (done) begin
                done_n++;
                done_cyc = cyc;
                chk("done_busy", busy, 0);
            end
            outstanding = outstanding + int'(acc_enb) - int'(pop);
            stall_prev  = m_valid && !m_ready;
            prev_data   = m_data;
            prev_last   = m_last;
        end
    end

    task automatic run_job(input int base, input int cnt, input int mode,
                           input bit ign);
        int sc, d0;
        @(posedge clk);
        #1;
        ready_mode = mode;
        pi = 0;
        beats = 0;
        first_cyc = -1;
        for (int i = 0; i < cnt; i++) begin
            exp_addr_q.push_back((base + i) % 16);
            exp_q.push_back(ref_row(mem[(base + i) % 16]));
        end
        d0 = done_n;
        start = 1'b1;
        base_addr = 4'(base);
        row_cnt = 5'(cnt);
        sc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (cnt > 0) chk("busy_after_start", busy, 1);
        if (ign && cnt > 1) begin
            start = 1'b1;
            base_addr = 4'(base + 7);
            row_cnt = 5'd5;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        for (int k = 0; k < 400 && done_n == d0; k++) @(posedge clk);
        chk("done_seen", done_n - d0, 1);
        chk("beat_count", beats, cnt);
        chk("reads_left", exp_addr_q.size(), 0);
        if (cnt == 0) begin
            chk("zero_done_cyc", done_cyc - sc, 1);
        end else begin
            chk("done_after_last", done_cyc - last_beat_cyc, 1);
            if (mode == 0) begin
                chk("first_lat", first_cyc - sc, 2);
                chk("throughput", last_beat_cyc - first_cyc, cnt - 1);
            end
        end
        exp_q.delete();
        exp_addr_q.delete();
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int d0;
        logic [7:0] lane_exp;
        rst_n = 1'b0;
        start = 1'b0;
        base_addr = '0;
        row_cnt = '0;
        done_n = 0;
        for (int i = 0; i < 16; i++)
            mem[i] = {$urandom, $urandom, $urandom, $urandom};
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_enb", acc_enb, 0);
        chk("rst_addr", acc_addrb, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_last", m_last, 0);
        chk("rst_data", m_data, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_job(0, 16, 0, 1'b0);
        run_job(14, 4, 0, 1'b0);
        run_job(3, 3, 2, 1'b1);
        run_job(7, 0, 0, 1'b0);

        mem[5][7:0] = 8'h80;
        run_job(5, 1, 0, 1'b0);
`ifdef ACC_DRAIN_RELU_EN
        lane_exp = 8'h00;
`else
        lane_exp = 8'h80;
`endif
        chk("relu_lane0", last_data[7:0], lane_exp);

        for (int j = 0; j < 10; j++)
            run_job($urandom_range(0, 15), $urandom_range(0, 16),
                    $urandom_range(0, 2), 1'($urandom % 2));

        ready_mode = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            exp_addr_q.push_back((9 + i) % 16);
            exp_q.push_back(ref_row(mem[(9 + i) % 16]));
        end
        beats = 0;
        start = 1'b1;
        base_addr = 4'd9;
        row_cnt = 5'd8;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < 50 && beats < 2; k++) @(posedge clk);
        chk("pre_rst_beats", beats >= 2, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_enb", acc_enb, 0);
        chk("mid_rst_addr", acc_addrb, 0);
        chk("mid_rst_valid", m_valid, 0);
        chk("mid_rst_last", m_last, 0);
        chk("mid_rst_data", m_data, 0);
        exp_q.delete();
        exp_addr_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        d0 = done_n;
        repeat (20) @(posedge clk);
        chk("post_rst_done", done_n - d0, 0);
        chk("post_rst_valid", m_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
